// File: rtl/data_mem_responder.sv
// Data-memory responder: cpu RAM port with write-first forwarding, an MMIO
// register window at the top of the address space, and a DMA stream reader
// on an independent read-first RAM port.
module data_mem_responder #(
    parameter int unsigned           DATA_WIDTH = 13,
    parameter logic [DATA_WIDTH-1:0] IO_BASE    = 13'h1FF0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] mem_din_addr,
    output logic [15:0]           mem_din,
    input  logic                  mem_dout_we,
    input  logic [DATA_WIDTH-1:0] mem_dout_addr,
    input  logic [15:0]           mem_dout,
    input  logic [15:0]           keys_in,
    input  logic                  vsync_in,
    output logic [15:0]           dma_data,
    output logic                  dma_valid,
    input  logic                  dma_ready,
    output logic                  dma_last,
    output logic                  dma_busy
);

    localparam int unsigned DEPTH = 1 << DATA_WIDTH;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_FETCH,
        DMA_SEND
    } dma_state_e;

    logic [15:0] ram_q [DEPTH];

    // Address decode for both cpu ports
    logic                  rd_io, wr_io, wr_ram, wr_reg;
    logic [DATA_WIDTH-1:0] rd_off, wr_off;

    assign rd_io  = (mem_din_addr >= IO_BASE);
    assign wr_io  = (mem_dout_addr >= IO_BASE);
    assign rd_off = mem_din_addr - IO_BASE;
    assign wr_off = mem_dout_addr - IO_BASE;
    assign wr_ram = mem_dout_we & ~wr_io;
    assign wr_reg = mem_dout_we & wr_io & (wr_off[DATA_WIDTH-1:4] == '0);

    // Synchronizers and MMIO registers
    logic [15:0]           keys_s1_q, keys_s2_q;
    logic                  vs_s1_q, vs_s2_q, vs_s3_q;
    logic                  vs_rise;
    logic [15:0]           frame_q, frame_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] src_q, src_d;
    logic [15:0]           len_q, len_d;
    logic                  start;
    logic [15:0]           mem_din_q, mem_din_d;

    // DMA engine state
    dma_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;

    assign vs_rise = vs_s2_q & ~vs_s3_q;
    assign start   = wr_reg & (wr_off[3:0] == 4'd5) & mem_dout[0];

    // RAM array write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram_q[mem_dout_addr] <= mem_dout;
        end
    end

    // MMIO register updates; a vsync edge wins over a W1C clear
    always_comb begin
        frame_d = frame_q;
        pend_d  = pend_q;
        src_d   = src_q;
        len_d   = len_q;
        if (vs_rise) begin
            frame_d = frame_q + 16'd1;
        end
        if (vs_rise) begin
            pend_d = 1'b1;
        end else if (wr_reg && wr_off[3:0] == 4'd2 && mem_dout[0]) begin
            pend_d = 1'b0;
        end
        if (wr_reg && wr_off[3:0] == 4'd3) begin
            src_d = mem_dout[DATA_WIDTH-1:0];
        end
        if (wr_reg && wr_off[3:0] == 4'd4) begin
            len_d = mem_dout;
        end
    end

    // cpu read mux: MMIO registers, forwarded write data, or RAM
    always_comb begin
        mem_din_d = '0;
        if (rd_io) begin
            if (rd_off[DATA_WIDTH-1:4] == '0) begin
                case (rd_off[3:0])
                    4'd0:    mem_din_d = keys_s2_q;
                    4'd1:    mem_din_d = frame_q;
                    4'd2:    mem_din_d = {15'd0, pend_q};
                    4'd3:    mem_din_d = 16'(src_q);
                    4'd4:    mem_din_d = len_q;
                    4'd5:    mem_din_d = {15'd0, busy_q};
                    default: mem_din_d = '0;
                endcase
            end
        end else if (wr_ram && mem_dout_addr == mem_din_addr) begin
            mem_din_d = mem_dout;
        end else begin
            mem_din_d = ram_q[mem_din_addr];
        end
    end

    // DMA next-state: fetch a word, present it, wait for the handshake
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        case (state_q)
            DMA_IDLE: begin
                if (start && len_q != 16'd0) begin
                    addr_d  = src_q;
                    cnt_d   = len_q;
                    busy_d  = 1'b1;
                    state_d = DMA_FETCH;
                end
            end
            DMA_FETCH: begin
                data_d  = ram_q[addr_q];
                valid_d = 1'b1;
                last_d  = (cnt_q == 16'd1);
                state_d = DMA_SEND;
            end
            DMA_SEND: begin
                if (dma_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    addr_d  = addr_q + DATA_WIDTH'(1);
                    cnt_d   = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        busy_d  = 1'b0;
                        state_d = DMA_IDLE;
                    end else begin
                        state_d = DMA_FETCH;
                    end
                end
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keys_s1_q <= '0;
            keys_s2_q <= '0;
            vs_s1_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            vs_s3_q   <= 1'b0;
            frame_q   <= '0;
            pend_q    <= 1'b0;
            src_q     <= '0;
            len_q     <= '0;
            mem_din_q <= '0;
            state_q   <= DMA_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            keys_s1_q <= keys_in;
            keys_s2_q <= keys_s1_q;
            vs_s1_q   <= vsync_in;
            vs_s2_q   <= vs_s1_q;
            vs_s3_q   <= vs_s2_q;
            frame_q   <= frame_d;
            pend_q    <= pend_d;
            src_q     <= src_d;
            len_q     <= len_d;
            mem_din_q <= mem_din_d;
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
        end
    end

    assign mem_din   = mem_din_q;
    assign dma_data  = data_q;
    assign dma_valid = valid_q;
    assign dma_last  = last_q;
    assign dma_busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: drivers push expected read data
// and expected DMA words into queues; monitors pop and compare.
module tb_data_mem_responder;

    localparam int          DW  = 13;
    localparam logic [12:0] IOB = 13'h1FF0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] mem_din_addr = '0;
    logic [15:0] mem_din;
    logic        mem_dout_we = 1'b0;
    logic [12:0] mem_dout_addr = '0;
    logic [15:0] mem_dout = '0;
    logic [15:0] keys_in = '0;
    logic        vsync_in = 1'b0;
    logic [15:0] dma_data;
    logic        dma_valid;
    logic        dma_ready = 1'b0;
    logic        dma_last;
    logic        dma_busy;

    data_mem_responder #(.DATA_WIDTH(DW), .IO_BASE(IOB)) dut (
        .clk(clk), .reset(reset),
        .mem_din_addr(mem_din_addr), .mem_din(mem_din),
        .mem_dout_we(mem_dout_we), .mem_dout_addr(mem_dout_addr), .mem_dout(mem_dout),
        .keys_in(keys_in), .vsync_in(vsync_in),
        .dma_data(dma_data), .dma_valid(dma_valid), .dma_ready(dma_ready),
        .dma_last(dma_last), .dma_busy(dma_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [15:0] mem_m [8192];
    bit          known_m [8192];
    logic [15:0] keys_m = '0;
    logic [15:0] frame_m = '0;
    bit          pend_m = 1'b0;
    logic [12:0] src_m = '0;
    logic [15:0] len_m = '0;
    bit          io_seen [16];
    logic [15:0] io_val [16];

    // mode 0: exact data, 1: data unknown, 2: data must differ from value
    typedef struct {
        logic [15:0] data;
        bit          last;
        int          mode;
    } dma_exp_t;

    dma_exp_t    dma_q[$];
    logic [15:0] rd_q[$];

    bit rd_pend = 1'b0;
    bit rd_pend_q = 1'b0;
    int ready_mode = 2;
    int valid_cycles = 0;

    function automatic void check(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endfunction

    function automatic logic [15:0] model_read(logic [12:0] a);
        int off;
        if (a >= IOB) begin
            off = int'(a - IOB);
            case (off)
                0: return keys_m;
                1: return frame_m;
                2: return {15'd0, pend_m};
                3: return {3'd0, src_m};
                4: return len_m;
                5: return {15'd0, dma_q.size() != 0};
                default: return 16'd0;
            endcase
        end
        return mem_m[a];
    endfunction

    function automatic void model_write(logic [12:0] a, logic [15:0] d);
        int off;
        logic [12:0] wa;
        dma_exp_t e;
        if (a >= IOB) begin
            off = int'(a - IOB);
            io_seen[off] = 1'b1;
            io_val[off] = d;
            case (off)
                2: if (d[0]) pend_m = 1'b0;
                3: src_m = d[12:0];
                4: len_m = d;
                5: if (d[0] && dma_q.size() == 0 && len_m != 0) begin
                    for (int i = 0; i < int'(len_m); i++) begin
                        wa = src_m + 13'(i);
                        e.last = (i == int'(len_m) - 1);
                        if (known_m[wa]) begin
                            e.mode = 0; e.data = mem_m[wa];
                        end else if (wa >= IOB && io_seen[int'(wa - IOB)]) begin
                            e.mode = 2; e.data = io_val[int'(wa - IOB)];
                        end else begin
                            e.mode = 1; e.data = '0;
                        end
                        dma_q.push_back(e);
                    end
                end
                default: ;
            endcase
        end else begin
            mem_m[a] = d;
            known_m[a] = 1'b1;
        end
    endfunction

    task automatic cpu_write(logic [12:0] a, logic [15:0] d);
        mem_dout_we = 1'b1; mem_dout_addr = a; mem_dout = d;
        model_write(a, d);
        @(negedge clk);
        mem_dout_we = 1'b0;
    endtask

    task automatic cpu_read(logic [12:0] a);
        mem_din_addr = a;
        rd_q.push_back(model_read(a));
        rd_pend = 1'b1;
        @(negedge clk);
        rd_pend = 1'b0;
    endtask

    task automatic cpu_wr_rd(logic [12:0] a, logic [15:0] d);
        mem_dout_we = 1'b1; mem_dout_addr = a; mem_dout = d;
        mem_din_addr = a;
        model_write(a, d);
        rd_q.push_back(model_read(a));
        rd_pend = 1'b1;
        @(negedge clk);
        rd_pend = 1'b0;
        mem_dout_we = 1'b0;
    endtask

    task automatic set_keys(logic [15:0] k);
        keys_in = k;
        repeat (2) @(negedge clk);
        keys_m = k;
    endtask

    task automatic vsync_pulse();
        vsync_in = 1'b1;
        repeat (3) @(negedge clk);
        frame_m++; pend_m = 1'b1;
        vsync_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic dma_start(logic [12:0] s, logic [15:0] l);
        cpu_write(IOB + 13'd3, {3'd0, s});
        cpu_write(IOB + 13'd4, l);
        cpu_write(IOB + 13'd5, 16'd1);
    endtask

    task automatic wait_dma_idle(string nm);
        int n = 0;
        while ((dma_q.size() != 0 || dma_busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 300) passes++;
        else $display("FAIL %s: dma timeout, %0d words left, busy=%b", nm, dma_q.size(), dma_busy);
    endtask

    // dma_ready driver, changes just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: dma_ready = 1'b0;
                1: dma_ready = 1'b1;
                default: dma_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Read monitor
    always @(posedge clk) rd_pend_q <= rd_pend;

    always @(negedge clk) begin
        if (reset && rd_pend_q) begin
            if (rd_q.size() == 0) begin
                checks++;
                $display("FAIL rd_scoreboard: got %h with no expected entry", mem_din);
            end else begin
                check("mem_din", mem_din, rd_q.pop_front());
            end
        end
    end

    // DMA stream monitor
    bit          prev_v = 1'b0;
    bit          prev_hs = 1'b0;
    logic [15:0] prev_d = '0;
    logic        prev_l = 1'b0;
    bit          busy_chk = 1'b0;

    always @(negedge clk) begin
        bit hs;
        dma_exp_t e;
        if (!reset) begin
            prev_v = 1'b0;
            busy_chk = 1'b0;
        end else begin
            if (dma_valid) valid_cycles++;
            if (busy_chk) begin
                check("busy_after_last", {15'd0, dma_busy}, 16'd0);
                busy_chk = 1'b0;
            end
            if (prev_v && !prev_hs) begin
                check("hold_valid", {15'd0, dma_valid}, 16'd1);
                check("hold_data", dma_data, prev_d);
                check("hold_last", {15'd0, dma_last}, {15'd0, prev_l});
            end
            hs = dma_valid && dma_ready;
            if (hs) begin
                if (dma_q.size() == 0) begin
                    checks++;
                    $display("FAIL dma_unexpected: got word %h with no expected entry", dma_data);
                end else begin
                    e = dma_q.pop_front();
                    if (e.mode == 0) check("dma_data", dma_data, e.data);
                    else if (e.mode == 2) begin
                        checks++;
                        if (dma_data !== e.data) passes++;
                        else $display("FAIL dma_raw_ram: got %h required anything but %h", dma_data, e.data);
                    end
                    check("dma_last", {15'd0, dma_last}, {15'd0, e.last});
                    check("dma_busy", {15'd0, dma_busy}, 16'd1);
                    if (e.last) busy_chk = 1'b1;
                end
            end
            prev_v = dma_valid; prev_d = dma_data; prev_l = dma_last; prev_hs = hs;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int vc;
        int op;
        bit seen;
        logic [12:0] a;

        // Reset values
        #12;
        check("rst_mem_din", mem_din, 16'd0);
        check("rst_dma_valid", {15'd0, dma_valid}, 16'd0);
        check("rst_dma_busy", {15'd0, dma_busy}, 16'd0);
        check("rst_dma_last", {15'd0, dma_last}, 16'd0);
        check("rst_dma_data", dma_data, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // CPU read/write and write-first forwarding
        cpu_write(13'h0010, 16'h1234);
        cpu_read(13'h0010);
        cpu_wr_rd(13'h0011, 16'hBEEF);
        cpu_read(13'h0011);

        // KEYS sync, MMIO writes never hit RAM, unlisted offsets
        set_keys(16'h00A5);
        cpu_read(IOB);
        cpu_write(IOB, 16'h5555);
        cpu_read(IOB);
        cpu_read(IOB + 13'd9);
        cpu_write(IOB + 13'd10, 16'hFFFF);
        cpu_read(IOB + 13'd10);
        ready_mode = 1;
        dma_start(IOB, 16'd1);
        wait_dma_idle("dma_1ff0");

        // FRAME / STATUS
        repeat (3) vsync_pulse();
        cpu_read(IOB + 13'd1);
        cpu_read(IOB + 13'd2);
        cpu_write(IOB + 13'd2, 16'h0001);
        cpu_read(IOB + 13'd2);
        vsync_in = 1'b1;
        repeat (2) @(negedge clk);
        cpu_write(IOB + 13'd2, 16'h0001);
        frame_m++; pend_m = 1'b1;
        cpu_read(IOB + 13'd2);
        cpu_read(IOB + 13'd1);
        vsync_in = 1'b0;
        repeat (3) @(negedge clk);
        cpu_write(IOB + 13'd2, 16'h0000);
        cpu_read(IOB + 13'd2);

        // Four-word transfer with random backpressure; restart while busy ignored
        for (int i = 0; i < 4; i++) cpu_write(13'h0100 + 13'(i), 16'(i + 1));
        ready_mode = 2;
        dma_start(13'h0100, 16'd4);
        cpu_write(IOB + 13'd3, 16'h0200);
        cpu_write(IOB + 13'd4, 16'd9);
        cpu_write(IOB + 13'd5, 16'd1);
        cpu_read(IOB + 13'd5);
        wait_dma_idle("dma_four");
        cpu_read(IOB + 13'd5);

        // Address wrap and zero-length start
        cpu_write(13'h0000, 16'(($urandom)));
        dma_start(13'h1FFF, 16'd2);
        wait_dma_idle("dma_wrap");
        vc = valid_cycles;
        dma_start(13'h0040, 16'd0);
        repeat (20) @(negedge clk);
        check("len0_no_valid", 16'(valid_cycles), 16'(vc));
        check("len0_busy", {15'd0, dma_busy}, 16'd0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) cpu_write(13'h0200 + 13'(i), 16'($urandom));
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: cpu_write(13'h0300 + 13'($urandom_range(0, 255)), 16'($urandom));
                1: cpu_read(13'h0200 + 13'($urandom_range(0, 79)));
                2: cpu_read(IOB + 13'($urandom_range(0, 15)));
                3: begin
                    ready_mode = int'($urandom_range(1, 2));
                    dma_start(13'h0200 + 13'($urandom_range(0, 60)), 16'($urandom_range(1, 8)));
                    wait_dma_idle("dma_random");
                end
                4: set_keys(16'($urandom));
                default: vsync_pulse();
            endcase
        end
        cpu_read(IOB + 13'd1);
        cpu_read(IOB + 13'd2);

        // Reset during SEND with the sink stalled
        ready_mode = 0;
        dma_start(13'h0100, 16'd4);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = dma_valid;
        end
        checks++;
        if (seen) passes++;
        else $display("FAIL rst_wait_valid: dma_valid never rose, got 0 required 1");
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", {15'd0, dma_valid}, 16'd0);
        check("async_rst_busy", {15'd0, dma_busy}, 16'd0);
        dma_q.delete();
        rd_q.delete();
        frame_m = '0; pend_m = 1'b0; src_m = '0; len_m = '0;
        @(negedge clk);
        check("rst_hold_mem_din", mem_din, 16'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        vc = valid_cycles;
        ready_mode = 1;
        cpu_read(IOB + 13'd1);
        cpu_read(IOB + 13'd2);
        cpu_read(IOB + 13'd4);
        repeat (20) @(negedge clk);
        check("post_rst_no_stream", 16'(valid_cycles), 16'(vc));
        cpu_read(13'h0010);
        repeat (3) @(negedge clk);
        check("rd_queue_drained", 16'(rd_q.size()), 16'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
